// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encodings and default widths for the PC sequencer
package pc_sequencer_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 11;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_RUN    = 3'd1,
    ST_HALTED = 3'd2,
    ST_FAULT  = 3'd3
  } state_t;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// rtl/pc_sequencer_return_stack.sv - LIFO of return addresses; one push or pop per cycle
module return_stack #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      count;
  logic [PW-1:0]    top_idx;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign top_idx = PW'(count - 1'b1);
  assign top     = mem[top_idx];

  // Pop wins over push so a stray simultaneous request can never grow the stack.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (pop && !empty) begin
      count <= count - 1'b1;
    end else if (push && !full) begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !pop && push && !full) begin
      mem[count[PW-1:0]] <= data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC selection FSM with call/return stack and sticky fault flags
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    STACK_DEPTH  = 8
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] CUR_ADDR,
  input  logic                  STALL,
  input  logic                  HALT,
  input  logic                  BR_TAKEN,
  input  logic [ADDR_WIDTH-1:0] BR_TARGET,
  input  logic                  JUMP,
  input  logic [ADDR_WIDTH-1:0] J_TARGET,
  input  logic                  CALL,
  input  logic                  RET,
  output logic                  WO,
  output logic [ADDR_WIDTH-1:0] NEXT_ADDR,
  output logic [2:0]            STATE,
  output logic                  STACK_OVF,
  output logic                  STACK_UNF
);

  state_t                  state_q, state_d;
  logic                    wo_q, wo_d;
  logic [ADDR_WIDTH-1:0]   next_q, next_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic                    push, pop;
  logic [ADDR_WIDTH-1:0]   seq_addr;
  logic [ADDR_WIDTH-1:0]   stack_top;
  logic                    stack_full, stack_empty;

  // Natural wrap at the top of the address space.
  assign seq_addr = CUR_ADDR + 1'b1;

  return_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (CLOCK),
    .reset (RESET),
    .push  (push),
    .pop   (pop),
    .data  (seq_addr),
    .top   (stack_top),
    .full  (stack_full),
    .empty (stack_empty)
  );

  always_comb begin
    state_d = state_q;
    wo_d    = 1'b0;
    next_d  = next_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        wo_d    = 1'b1;
        next_d  = RESET_VECTOR;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (HALT) begin
          state_d = ST_HALTED;
        end else if (!STALL) begin
          // A stalled cycle drops every request; the requester re-presents it.
          if (RET) begin
            if (stack_empty) begin
              unf_d   = 1'b1;
              state_d = ST_FAULT;
            end else begin
              pop    = 1'b1;
              wo_d   = 1'b1;
              next_d = stack_top;
            end
          end else if (CALL) begin
            if (stack_full) begin
              ovf_d   = 1'b1;
              state_d = ST_FAULT;
            end else begin
              push   = 1'b1;
              wo_d   = 1'b1;
              next_d = J_TARGET;
            end
          end else if (JUMP) begin
            wo_d   = 1'b1;
            next_d = J_TARGET;
          end else if (BR_TAKEN) begin
            wo_d   = 1'b1;
            next_d = BR_TARGET;
          end else begin
            wo_d   = 1'b1;
            next_d = seq_addr;
          end
        end
      end
      ST_HALTED, ST_FAULT: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= ST_LOAD;
      wo_q    <= 1'b0;
      next_q  <= RESET_VECTOR;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wo_q    <= wo_d;
      next_q  <= next_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign WO        = wo_q;
  assign NEXT_ADDR = next_q;
  assign STATE     = state_q;
  assign STACK_OVF = ovf_q;
  assign STACK_UNF = unf_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 11: width of every address port; matches the program counter.
REQ-002 Parameter RESET_VECTOR, default 0: first fetch address after reset.
REQ-003 Parameter STACK_DEPTH, default 8: return-stack entries; power of two.
REQ-004 CLOCK  in  1: single clock; all state updates on posedge. The program counter latches on the following negedge.
REQ-005 RESET  in  1: synchronous, active-high reset.
REQ-006 CUR_ADDR  in  ADDR_WIDTH: program counter output, fed back.
REQ-007 STALL  in  1: suppress the PC update this cycle.
REQ-008 HALT  in  1: stop sequencing.
REQ-009 BR_TAKEN  in  1: conditional branch resolved taken.
REQ-010 BR_TARGET  in  ADDR_WIDTH: branch target address.
REQ-011 JUMP  in  1: unconditional jump.
REQ-012 J_TARGET  in  ADDR_WIDTH: jump or call target address.
REQ-013 CALL  in  1: call to J_TARGET; pushes the return address.
REQ-014 RET  in  1: return to the popped address.
REQ-015 WO  out  1: write enable to the program counter.
REQ-016 NEXT_ADDR  out  ADDR_WIDTH: address to the program counter input.
REQ-017 STATE  out  3: encoded FSM state.
REQ-018 STACK_OVF  out  1: sticky flag; a push was attempted on a full stack.
REQ-019 STACK_UNF  out  1: sticky flag; a pop was attempted on an empty stack.

Function
REQ-020 FSM states: LOAD=0, RUN=1, HALTED=2, FAULT=3. Encodings 4-7 are unused and recover to LOAD.
REQ-021 LOAD lasts exactly one cycle. WO=1 and NEXT_ADDR=RESET_VECTOR are registered, then the FSM goes to RUN unconditionally; request inputs are ignored.
REQ-022 In RUN, inputs are sampled at posedge k. WO and NEXT_ADDR are registered at posedge k and valid until posedge k+1, so the PC updates at the negedge of cycle k (latency 0.5 cycle).
REQ-023 RUN priority: HALT > STALL > RET > CALL > JUMP > BR_TAKEN > sequential.
REQ-024 HALT: WO=0, state goes to HALTED; no other request is acted on.
REQ-025 STALL without HALT: WO=0, NEXT_ADDR holds its value, stack unchanged. Requests are dropped, and the requester holds them until STALL falls.
REQ-026 RET: pop; NEXT_ADDR=popped value, WO=1. If the stack is empty: WO=0, STACK_UNF=1, state goes to FAULT.
REQ-027 CALL: push CUR_ADDR+1; NEXT_ADDR=J_TARGET, WO=1. If the stack is full: WO=0, STACK_OVF=1, state goes to FAULT, stack unchanged.
REQ-028 Simultaneous CALL and RET: only RET is performed.
REQ-029 JUMP: NEXT_ADDR=J_TARGET. BR_TAKEN: NEXT_ADDR=BR_TARGET. Sequential: NEXT_ADDR=CUR_ADDR+1. All three drive WO=1.
REQ-030 All increments are modulo 2^ADDR_WIDTH: CUR_ADDR=all-ones gives 0, with no flag.
REQ-031 HALTED and FAULT: WO=0 and NEXT_ADDR held. These states are left only by RESET.
REQ-032 The stack is LIFO with STACK_DEPTH entries, and exactly one push or pop occurs per cycle at most.

Reset
REQ-033 RESET sampled high: state goes to LOAD, WO=0, NEXT_ADDR=RESET_VECTOR, stack emptied, STACK_OVF=0, STACK_UNF=0, STATE=0.
REQ-034 RESET overrides every input in every state, including in the middle of a CALL or RET. No push or pop commits in a cycle where RESET is high.
REQ-035 The first cycle with RESET low performs the LOAD action.

Structure
REQ-036 A shared package holds the state encodings (LOAD, RUN, HALTED, FAULT) and the default ADDR_WIDTH.
REQ-037 The return stack is a sub-module, return_stack, parameterised by width and depth.
   - Ports: push, pop, data in, top, full, empty.
   - return_stack uses the same clock and reset as pc_sequencer.

Verification
REQ-038 Reset then 4 idle RUN cycles with CUR_ADDR tracking a PC model: NEXT_ADDR sequence is 0, 1, 2, 3, 4, with WO=1 in every cycle.
REQ-039 CUR_ADDR=0x7FF with sequential advance: NEXT_ADDR=0x000, WO=1, no flag set.
REQ-040 CALL with J_TARGET=0x100 at CUR_ADDR=0x020, then RET at 0x105: NEXT_ADDR=0x100, then 0x021.
REQ-041 Nine nested CALLs (depth 8): the ninth gives WO=0, STACK_OVF=1, STATE=FAULT, held until RESET. RET on an empty stack gives STACK_UNF=1, STATE=FAULT.
REQ-042 STALL high for 3 cycles with JUMP asserted: WO=0 for all 3 cycles. JUMP held after STALL falls: NEXT_ADDR=J_TARGET in the next cycle.
REQ-043 CALL and RET together with one entry 0x0AA stacked: NEXT_ADDR=0x0AA and the stack ends empty. RESET asserted during a CALL: the stack stays empty and NEXT_ADDR=RESET_VECTOR.
